// File: rtl/arb_rr4_if.sv
// rtl/arb_rr4_if.sv - request/grant bundle between requesters and the arb_rr4 arbiter
interface arb_rr4_if;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_id,
        input  busy,
        input  timeout
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_id,
        output busy,
        output timeout
    );
endinterface

// File: rtl/arb_rr4.sv
// rtl/arb_rr4.sv - four-requester round-robin arbiter, optional grant timeout under ARB_RR4_TIMEOUT_EN
module arb_rr4 #(
    parameter int MAX_HOLD = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    arb_rr4_if.slave  bus
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_ptr, w_ptr_nxt;
    logic [3:0] r_gnt, w_gnt_nxt;
    logic [1:0] r_gnt_id, w_gnt_id_nxt;
    logic       r_busy, w_busy_nxt;
    logic       w_timeout_nxt;

    logic       w_found;
    logic [1:0] w_win;
    logic [1:0] w_idx;

`ifdef ARB_RR4_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] r_hold_cnt;
    logic       r_timeout;
`else
    logic [7:0] w_unused_max_hold;
    assign w_unused_max_hold = 8'(MAX_HOLD);
`endif

    // Rotating priority search: first set request starting at ptr, wrapping mod 4
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = r_ptr;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Next-state and next-output logic for the IDLE/BUSY grant FSM
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_busy_nxt    = r_busy;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_gnt_nxt    = 4'b0000;
                w_gnt_id_nxt = 2'd0;
                w_busy_nxt   = 1'b0;
                if (bus.en && w_found) begin
                    w_gnt_nxt    = 4'b0001 << w_win;
                    w_gnt_id_nxt = w_win;
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = S_BUSY;
                end
            end
            S_BUSY: begin
                // A release wins over a coincident timeout threshold
                if (!bus.req[r_gnt_id]) begin
                    w_gnt_nxt    = 4'b0000;
                    w_gnt_id_nxt = 2'd0;
                    w_busy_nxt   = 1'b0;
                    w_ptr_nxt    = r_gnt_id + 2'd1;
                    w_state_nxt  = S_IDLE;
                end
`ifdef ARB_RR4_TIMEOUT_EN
                else if (r_hold_cnt == HOLD_LAST) begin
                    w_gnt_nxt     = 4'b0000;
                    w_gnt_id_nxt  = 2'd0;
                    w_busy_nxt    = 1'b0;
                    w_ptr_nxt     = r_gnt_id + 2'd1;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                end
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, pointer and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ptr    <= 2'd0;
            r_gnt    <= 4'b0000;
            r_gnt_id <= 2'd0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_gnt    <= w_gnt_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

`ifdef ARB_RR4_TIMEOUT_EN
    // Hold counter runs only while a grant is active; timeout is a one-cycle pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold_cnt <= 8'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_hold_cnt <= (r_state == S_BUSY) ? r_hold_cnt + 8'd1 : 8'd0;
            r_timeout  <= w_timeout_nxt;
        end
    end
    assign bus.timeout = r_timeout;
`else
    assign bus.timeout = w_timeout_nxt & 1'b0;
`endif

    assign bus.gnt    = r_gnt;
    assign bus.gnt_id = r_gnt_id;
    assign bus.busy   = r_busy;

endmodule

// File: tb/tb_arb_rr4.sv
// tb/tb_arb_rr4.sv - directed self-checking bench for arb_rr4
module tb_arb_rr4;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    logic [7:0] got;
    logic [7:0] exp;

    arb_rr4_if bus ();

    arb_rr4 #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bus.en  = 1'b1;
        bus.req = 4'b1111;
        step();
        step();
        got = {bus.gnt, bus.gnt_id, bus.busy, bus.timeout};
        n_vec++;
        if (got !== 8'b0000_00_0_0) begin
            n_err++;
            $display("FAIL reset_in: got %b want %b", got, 8'b0000_00_0_0);
        end
        rst_n   = 1'b1;
        bus.req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            step();
            got = {bus.gnt, bus.gnt_id, bus.busy, bus.timeout};
            n_vec++;
            if (got !== 8'b0000_00_0_0) begin
                n_err++;
                $display("FAIL reset_idle[%0d]: got %b want %b", i, got, 8'b0000_00_0_0);
            end
        end
    endtask

    task automatic test_rotation();
        int order [5] = '{0, 1, 2, 3, 0};
        bus.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 3; c++) begin
                step();
                exp = {4'b0001 << order[g], 2'(order[g]), 1'b1, 1'b0};
                got = {bus.gnt, bus.gnt_id, bus.busy, bus.timeout};
                n_vec++;
                if (got !== exp || !$onehot0(bus.gnt)) begin
                    n_err++;
                    $display("FAIL rotation g%0d c%0d: got %b want %b", g, c, got, exp);
                end
            end
            bus.req = 4'b1111 & ~(4'b0001 << order[g]);
            step();
            got = {bus.gnt, bus.gnt_id, bus.busy, bus.timeout};
            n_vec++;
            if (got !== 8'b0000_00_0_0) begin
                n_err++;
                $display("FAIL rotation_release g%0d: got %b want %b", g, got, 8'b0000_00_0_0);
            end
            bus.req = 4'b1111;
        end
        bus.req = 4'b0000;
        step();
    endtask

    task automatic test_single();
        bus.req = 4'b0100;
        step();
        got = {bus.gnt, bus.gnt_id, bus.busy, bus.timeout};
        n_vec++;
        if (got !== 8'b0100_10_1_0) begin
            n_err++;
            $display("FAIL single_grant: got %b want %b", got, 8'b0100_10_1_0);
        end
        bus.req = 4'b0110;
        step();
        got = {bus.gnt, bus.gnt_id, bus.busy, bus.timeout};
        n_vec++;
        if (got !== 8'b0100_10_1_0) begin
            n_err++;
            $display("FAIL single_hold: got %b want %b", got, 8'b0100_10_1_0);
        end
        bus.req = 4'b0000;
        step();
        got = {bus.gnt, bus.gnt_id, bus.busy, bus.timeout};
        n_vec++;
        if (got !== 8'b0000_00_0_0) begin
            n_err++;
            $display("FAIL single_release: got %b want %b", got, 8'b0000_00_0_0);
        end
    endtask

    task automatic test_wrap();
        bus.req = 4'b1001;
        step();
        got = {bus.gnt, bus.gnt_id, bus.busy, bus.timeout};
        n_vec++;
        if (got !== 8'b1000_11_1_0) begin
            n_err++;
            $display("FAIL wrap_grant3: got %b want %b", got, 8'b1000_11_1_0);
        end
        bus.req = 4'b0001;
        step();
        got = {bus.gnt, bus.gnt_id, bus.busy, bus.timeout};
        n_vec++;
        if (got !== 8'b0000_00_0_0) begin
            n_err++;
            $display("FAIL wrap_turnaround: got %b want %b", got, 8'b0000_00_0_0);
        end
        bus.req = 4'b1001;
        step();
        got = {bus.gnt, bus.gnt_id, bus.busy, bus.timeout};
        n_vec++;
        if (got !== 8'b0001_00_1_0) begin
            n_err++;
            $display("FAIL wrap_grant0: got %b want %b", got, 8'b0001_00_1_0);
        end
        bus.req = 4'b0000;
        step();
    endtask

    task automatic test_enable();
        bus.en  = 1'b0;
        bus.req = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            step();
            got = {bus.gnt, bus.gnt_id, bus.busy, bus.timeout};
            n_vec++;
            if (got !== 8'b0000_00_0_0) begin
                n_err++;
                $display("FAIL en_blocked[%0d]: got %b want %b", i, got, 8'b0000_00_0_0);
            end
        end
        bus.en = 1'b1;
        step();
        got = {bus.gnt, bus.gnt_id, bus.busy, bus.timeout};
        n_vec++;
        if (got !== 8'b0010_01_1_0) begin
            n_err++;
            $display("FAIL en_grant: got %b want %b", got, 8'b0010_01_1_0);
        end
        bus.en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            got = {bus.gnt, bus.gnt_id, bus.busy, bus.timeout};
            n_vec++;
            if (got !== 8'b0010_01_1_0) begin
                n_err++;
                $display("FAIL en_low_busy[%0d]: got %b want %b", i, got, 8'b0010_01_1_0);
            end
        end
        bus.req = 4'b0000;
        step();
        bus.req = 4'b0010;
        step();
        got = {bus.gnt, bus.gnt_id, bus.busy, bus.timeout};
        n_vec++;
        if (got !== 8'b0000_00_0_0) begin
            n_err++;
            $display("FAIL en_low_regrant: got %b want %b", got, 8'b0000_00_0_0);
        end
        bus.req = 4'b0000;
        bus.en  = 1'b1;
        step();
    endtask

    task automatic test_short_grant();
        bus.req = 4'b0100;
        step();
        bus.req = 4'b0000;
        got = {bus.gnt, bus.gnt_id, bus.busy, bus.timeout};
        n_vec++;
        if (got !== 8'b0100_10_1_0) begin
            n_err++;
            $display("FAIL short_grant: got %b want %b", got, 8'b0100_10_1_0);
        end
        step();
        got = {bus.gnt, bus.gnt_id, bus.busy, bus.timeout};
        n_vec++;
        if (got !== 8'b0000_00_0_0) begin
            n_err++;
            $display("FAIL short_release: got %b want %b", got, 8'b0000_00_0_0);
        end
    endtask

    task automatic test_reset_mid();
        bus.req = 4'b0001;
        step();
        step();
        rst_n = 1'b0;
        step();
        got = {bus.gnt, bus.gnt_id, bus.busy, bus.timeout};
        n_vec++;
        if (got !== 8'b0000_00_0_0) begin
            n_err++;
            $display("FAIL reset_mid: got %b want %b", got, 8'b0000_00_0_0);
        end
        rst_n   = 1'b1;
        bus.req = 4'b1100;
        step();
        got = {bus.gnt, bus.gnt_id, bus.busy, bus.timeout};
        n_vec++;
        if (got !== 8'b0100_10_1_0) begin
            n_err++;
            $display("FAIL reset_ptr: got %b want %b", got, 8'b0100_10_1_0);
        end
        bus.req = 4'b0000;
        step();
    endtask

`ifdef ARB_RR4_TIMEOUT_EN
    task automatic test_timeout();
        bus.req = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            step();
            got = {bus.gnt, bus.gnt_id, bus.busy, bus.timeout};
            n_vec++;
            if (got !== 8'b0001_00_1_0) begin
                n_err++;
                $display("FAIL timeout_hold[%0d]: got %b want %b", i, got, 8'b0001_00_1_0);
            end
        end
        step();
        got = {bus.gnt, bus.gnt_id, bus.busy, bus.timeout};
        n_vec++;
        if (got !== 8'b0000_00_0_1) begin
            n_err++;
            $display("FAIL timeout_pulse: got %b want %b", got, 8'b0000_00_0_1);
        end
        step();
        got = {bus.gnt, bus.gnt_id, bus.busy, bus.timeout};
        n_vec++;
        if (got !== 8'b0001_00_1_0) begin
            n_err++;
            $display("FAIL timeout_regrant: got %b want %b", got, 8'b0001_00_1_0);
        end
        bus.req = 4'b0000;
        step();
        step();
    endtask
`else
    task automatic test_hold_long();
        bus.req = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            step();
            got = {bus.gnt, bus.gnt_id, bus.busy, bus.timeout};
            n_vec++;
            if (got !== 8'b0001_00_1_0) begin
                n_err++;
                $display("FAIL hold_long[%0d]: got %b want %b", i, got, 8'b0001_00_1_0);
            end
        end
        bus.req = 4'b0000;
        step();
        step();
    endtask
`endif

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        bus.en  = 1'b0;
        bus.req = 4'b0000;
        #1;
        test_reset();
        test_rotation();
        test_single();
        test_wrap();
        test_enable();
        test_short_grant();
        test_reset_mid();
`ifdef ARB_RR4_TIMEOUT_EN
        test_timeout();
`else
        test_hold_long();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
